// File: rtl/dispatcher_rr_n_if.sv
// rtl/dispatcher_rr_n_if.sv - stream bundle between upstream, dispatcher and N consumers
// slave is the dispatcher's view; master is the upstream/consumer side.
interface dispatcher_rr_n_if #(
  parameter int DWIDTH = 16,
  parameter int N      = 2
);
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              out_valid [N];
  logic [DWIDTH-1:0] out_data  [N];
  logic              out_ready [N];

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dispatcher_rr_n.sv
// rtl/dispatcher_rr_n.sv - round-robin 1-to-N stream dispatcher with one-entry slots
// Each accepted item goes to the first free slot at or after ptr, circularly.
module dispatcher_rr_n #(
  parameter int DWIDTH = 16,
  parameter int N      = 2
) (
  input  logic               clk,
  input  logic               reset,
  dispatcher_rr_n_if.slave   bus,
  output logic               busy
);
  localparam int            PW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [N-1:0]      full_q, full_d;
  logic [DWIDTH-1:0] data_q [N];
  logic [DWIDTH-1:0] data_d [N];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     sel;
  logic [PW:0]       idx;
  logic              rdy;
  logic              accept;

  // Walk offsets from farthest to nearest so the closest free slot to ptr wins.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (!full_q[idx[PW-1:0]]) begin
        sel = idx[PW-1:0];
      end
    end
  end

  assign rdy    = |(~full_q);
  assign accept = bus.in_valid & rdy;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    ptr_d  = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (full_q[i] && bus.out_ready[i]) begin
        full_d[i] = 1'b0;
      end
    end
    // sel is always an empty slot, so a load never collides with a drain.
    if (accept) begin
      full_d[sel] = 1'b1;
      data_d[sel] = bus.in_data;
      ptr_d       = (sel == LAST) ? '0 : sel + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= '0;
      ptr_q  <= '0;
      for (int i = 0; i < N; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      ptr_q  <= ptr_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.out_valid[i] = full_q[i];
      bus.out_data[i]  = data_q[i];
    end
  end

  assign bus.in_ready = rdy;
  assign busy         = |full_q;
endmodule

// File: tb/tb_dispatcher_rr_n.sv
// tb/tb_dispatcher_rr_n.sv - randomized and directed checks of dispatcher_rr_n (N=4 and N=1)
module tb_dispatcher_rr_n;
  localparam int DW = 16;
  localparam int N4 = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy4, busy1;

  always #5 clk = ~clk;

  dispatcher_rr_n_if #(.DWIDTH(DW), .N(N4)) bus4 ();
  dispatcher_rr_n_if #(.DWIDTH(DW), .N(1))  bus1 ();

  dispatcher_rr_n #(.DWIDTH(DW), .N(N4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave),
    .busy  (busy4)
  );

  dispatcher_rr_n #(.DWIDTH(DW), .N(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave),
    .busy  (busy1)
  );

  int n_cmp = 0;
  int n_err = 0;

  bit          m_full [N4];
  logic [15:0] m_data [N4];
  int          m_ptr;

  bit          acc;
  int          slot;
  bit          pend;
  bit          v;
  logic [15:0] pd;
  logic [3:0]  rdy;
  int          thr;
  bit          m1_full;
  logic [15:0] m1_data;
  int          n1_acc;
  int          n1_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N4; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = 16'h0;
    end
    m_ptr   = 0;
    m1_full = 1'b0;
    m1_data = 16'h0;
  endtask

  task automatic check_dut4(input string ph);
    bit any_free;
    bit any_full;
    any_free = 1'b0;
    any_full = 1'b0;
    for (int i = 0; i < N4; i++) begin
      check_eq($sformatf("%s out_valid[%0d]", ph, i), 32'(bus4.out_valid[i]), 32'(m_full[i]));
      check_eq($sformatf("%s out_data[%0d]", ph, i), 32'(bus4.out_data[i]), 32'(m_data[i]));
      if (m_full[i]) any_full = 1'b1;
      else           any_free = 1'b1;
    end
    check_eq($sformatf("%s in_ready", ph), 32'(bus4.in_ready), 32'(any_free));
    check_eq($sformatf("%s busy", ph), 32'(busy4), 32'(any_full));
  endtask

  // One cycle: check current state at negedge, drive inputs, predict the next state.
  task automatic step4(input string ph, input bit vin, input logic [15:0] d,
                       input logic [3:0] r, output bit a, output int s);
    @(negedge clk);
    check_dut4(ph);
    bus4.in_valid = vin;
    bus4.in_data  = d;
    for (int i = 0; i < N4; i++) bus4.out_ready[i] = r[i];
    s = -1;
    for (int k = 0; k < N4; k++) begin
      if (s < 0 && !m_full[(m_ptr + k) % N4]) s = (m_ptr + k) % N4;
    end
    a = vin && (s >= 0);
    for (int i = 0; i < N4; i++) begin
      if (m_full[i] && r[i]) m_full[i] = 1'b0;
    end
    if (a) begin
      m_full[s] = 1'b1;
      m_data[s] = d;
      m_ptr     = (s + 1) % N4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus4.in_valid = 1'b1;
    bus4.in_data  = 16'hBEEF;
    for (int i = 0; i < N4; i++) bus4.out_ready[i] = 1'b0;
    #1;
    model_reset();
    check_dut4("reset_async");
    check_eq("reset in_ready", 32'(bus4.in_ready), 32'd1);
    check_eq("reset busy", 32'(busy4), 32'd0);
    check_eq("reset n1 in_ready", 32'(bus1.in_ready), 32'd1);
    check_eq("reset n1 out_valid", 32'(bus1.out_valid[0]), 32'd0);
    repeat (2) @(negedge clk);
    check_dut4("reset_hold");
    reset         = 1'b1;
    bus4.in_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.in_data  = '0;
    for (int i = 0; i < N4; i++) bus4.out_ready[i] = 1'b0;
    bus1.in_valid     = 1'b0;
    bus1.in_data      = '0;
    bus1.out_ready[0] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) step4("prefill", 1'b1, 16'(16'h0C0 + i), 4'b0000, acc, slot);
    step4("prefill", 1'b0, 16'h0, 4'b0000, acc, slot);
    do_reset();
    step4("post_reset", 1'b1, 16'hAAAA, 4'b0000, acc, slot);
    step4("post_reset", 1'b0, 16'h0, 4'b0000, acc, slot);
    check_eq("first item slot0 valid", 32'(bus4.out_valid[0]), 32'd1);
    check_eq("first item slot0 data", 32'(bus4.out_data[0]), 32'hAAAA);

    do_reset();
    for (int i = 0; i < 8; i++) step4("stream", 1'b1, 16'(16'h10 + i), 4'b1111, acc, slot);
    step4("stream", 1'b0, 16'h0, 4'b1111, acc, slot);

    do_reset();
    for (int i = 0; i < 6; i++) step4("stall", 1'b1, 16'(16'hA0 + i), 4'b1101, acc, slot);
    step4("stall", 1'b0, 16'h0, 4'b1101, acc, slot);
    check_eq("stall slot1 held", 32'(bus4.out_data[1]), 32'hA1);
    step4("stall", 1'b1, 16'hB0, 4'b0000, acc, slot);
    step4("stall", 1'b0, 16'h0, 4'b0000, acc, slot);
    check_eq("stall ptr3 next slot3", 32'(bus4.out_data[3]), 32'hB0);

    do_reset();
    for (int i = 1; i <= 4; i++) step4("full", 1'b1, 16'(i), 4'b0000, acc, slot);
    step4("full", 1'b1, 16'h05, 4'b0000, acc, slot);
    check_eq("full in_ready", 32'(bus4.in_ready), 32'd0);
    step4("full", 1'b1, 16'h05, 4'b0100, acc, slot);
    step4("full", 1'b1, 16'h05, 4'b0000, acc, slot);
    check_eq("full in_ready back", 32'(bus4.in_ready), 32'd1);
    step4("full", 1'b0, 16'h0, 4'b0000, acc, slot);
    check_eq("full 0x05 in slot2", 32'(bus4.out_data[2]), 32'h05);
    check_eq("full slot2 valid", 32'(bus4.out_valid[2]), 32'd1);

    do_reset();
    step4("simul", 1'b1, 16'h11, 4'b0000, acc, slot);
    step4("simul", 1'b1, 16'h22, 4'b0000, acc, slot);
    step4("simul", 1'b1, 16'h33, 4'b0001, acc, slot);
    step4("simul", 1'b1, 16'h44, 4'b0000, acc, slot);
    step4("simul", 1'b1, 16'h55, 4'b0000, acc, slot);
    step4("simul", 1'b0, 16'h0, 4'b0000, acc, slot);
    check_eq("simul 0x33 slot2", 32'(bus4.out_data[2]), 32'h33);
    check_eq("simul 0x55 slot0", 32'(bus4.out_data[0]), 32'h55);

    do_reset();
    pend = 1'b0;
    v    = 1'b0;
    pd   = '0;
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) thr = $urandom_range(10, 100);
      if (!pend) begin
        v  = ($urandom_range(0, 3) != 0);
        pd = 16'($urandom);
      end
      for (int i = 0; i < N4; i++) rdy[i] = ($urandom_range(0, 99) < thr);
      step4("random", v, pd, rdy, acc, slot);
      pend = v && !acc;
    end
    step4("random", 1'b0, 16'h0, 4'b0000, acc, slot);

    n1_acc = 0;
    n1_out = 0;
    bus1.out_ready[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq($sformatf("n1 in_ready c%0d", c), 32'(bus1.in_ready), 32'(c % 2 == 0));
      check_eq($sformatf("n1 out_valid c%0d", c), 32'(bus1.out_valid[0]), 32'(m1_full));
      check_eq($sformatf("n1 busy c%0d", c), 32'(busy1), 32'(m1_full));
      if (m1_full) begin
        check_eq($sformatf("n1 out_data c%0d", c), 32'(bus1.out_data[0]), 32'(m1_data));
        n1_out++;
      end
      bus1.in_valid = 1'b1;
      bus1.in_data  = 16'(16'h100 + n1_acc);
      if (!m1_full) begin
        m1_full = 1'b1;
        m1_data = bus1.in_data;
        n1_acc++;
      end else begin
        m1_full = 1'b0;
      end
    end
    bus1.in_valid = 1'b0;
    @(negedge clk);
    if (m1_full) begin
      check_eq("n1 last data", 32'(bus1.out_data[0]), 32'(m1_data));
      n1_out++;
    end
    check_eq("n1 none lost", 32'(n1_out), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
